// File: rtl/stepper_pio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_pkg
//  Brief    : Register map, CTRL layout and coil tables for stepper_pio_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
package stepper_pkg;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_DIV    = 2'd1;
    localparam logic [1:0] c_ADDR_STEPS  = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    localparam int c_CTRL_EN     = 0;
    localparam int c_CTRL_DIR    = 1;
    localparam int c_CTRL_HALF   = 2;
    localparam int c_CTRL_CONT   = 3;
    localparam int c_CTRL_IRQ_EN = 4;
    localparam int c_CTRL_BITS   = 5;

    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_DONE    = 1;
    localparam int c_STAT_IDX_LSB = 4;

    typedef struct packed {
        logic irq_en;
        logic cont;
        logic half;
        logic dir;
        logic en;
    } ctrl_t;

    // Entry 0 sits in the low nibble; full-step mode uses only the odd entries.
    localparam logic [7:0][3:0] c_HALF_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] w_delta;
        logic [2:0] w_next;
        w_delta = half ? 3'd1 : 3'd2;
        w_next  = dir ? (idx + w_delta) : (idx - w_delta);
        return half ? w_next : (w_next | 3'b001);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_pio_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_pio_ctrl_if
//  Brief    : Avalon-MM slave bus bundle for the stepper controller.
//  Revision : 1.0  initial release
// ============================================================================
interface stepper_pio_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata);
    modport master (output address, chipselect, write_n, writedata,
                    input  readdata);
endinterface
`default_nettype wire

// File: rtl/stepper_rate_div.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_rate_div
//  Brief    : Step-period divider; one-cycle step pulse every DIV+1 clocks.
//  Revision : 1.0  initial release
// ============================================================================
module stepper_rate_div #(
    parameter int DIV_WIDTH = 24
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 run,
    input  wire logic                 clr,
    input  wire logic [DIV_WIDTH-1:0] div,
    output logic                      step
);
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_hit;

    assign w_hit = (r_cnt == div);
    // The pulse is not masked by clr so a coincident register write still advances idx.
    assign step  = run & w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!run || clr || w_hit)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule
`default_nettype wire

// File: rtl/stepper_pio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_pio_ctrl
//  Brief    : Avalon-MM unipolar stepper sequencer with rate, count and IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module stepper_pio_ctrl
    import stepper_pkg::*;
#(
    parameter int COILS     = 4,
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    stepper_pio_ctrl_if.slave  bus,
    output logic [COILS-1:0]   out_port,
    output logic               irq
);
    generate
        if (COILS != 4) begin : g_coils_check
            $error("stepper_pio_ctrl: coil tables are defined for COILS = 4 only");
        end
    endgenerate

    ctrl_t                r_ctrl;
    logic [DIV_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_rem;
    logic [2:0]           r_idx;
    logic                 r_done;

    logic        w_wr, w_wr_ctrl, w_wr_div, w_wr_steps, w_wr_status;
    logic        w_run, w_step, w_step_dec;
    logic [31:0] w_readdata;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wr_ctrl   = w_wr & (bus.address == c_ADDR_CTRL);
    assign w_wr_div    = w_wr & (bus.address == c_ADDR_DIV);
    assign w_wr_steps  = w_wr & (bus.address == c_ADDR_STEPS);
    assign w_wr_status = w_wr & (bus.address == c_ADDR_STATUS);

    assign w_run      = r_ctrl.en & (r_ctrl.cont | (r_rem != '0));
    // A STEPS write in the step cycle overrides the decrement and suppresses DONE.
    assign w_step_dec = w_step & ~r_ctrl.cont & ~w_wr_steps;

    stepper_rate_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rate_div (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_run),
        .clr     (w_wr_steps | w_wr_div),
        .div     (r_div),
        .step    (w_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_idx  <= 3'd1;
            r_done <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= ctrl_t'(bus.writedata[c_CTRL_BITS-1:0]);
            if (w_wr_div)
                r_div <= bus.writedata[DIV_WIDTH-1:0];

            if (w_wr_steps)
                r_rem <= bus.writedata[CNT_WIDTH-1:0];
            else if (w_step_dec)
                r_rem <= r_rem - 1'b1;

            if (w_step)
                r_idx <= next_idx(r_idx, r_ctrl.dir, r_ctrl.half);

            if (w_step_dec && (r_rem == CNT_WIDTH'(1)))
                r_done <= 1'b1;
            else if (w_wr_status && bus.writedata[c_STAT_DONE])
                r_done <= 1'b0;
        end
    end

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            c_ADDR_CTRL:  w_readdata[c_CTRL_BITS-1:0] = r_ctrl;
            c_ADDR_DIV:   w_readdata[DIV_WIDTH-1:0]   = r_div;
            c_ADDR_STEPS: w_readdata[CNT_WIDTH-1:0]   = r_rem;
            default: begin
                w_readdata[c_STAT_BUSY]                       = w_run;
                w_readdata[c_STAT_DONE]                       = r_done;
                w_readdata[c_STAT_IDX_LSB+2:c_STAT_IDX_LSB]   = r_idx;
            end
        endcase
    end

    assign bus.readdata = w_readdata;
    assign out_port     = r_ctrl.en ? COILS'(c_HALF_TABLE[r_idx]) : '0;
    assign irq          = r_done & r_ctrl.irq_en;
endmodule
`default_nettype wire

// File: doc/stepper_pio_ctrl.md
Name: stepper_pio_ctrl

Overview:
- Parametrised successor to the 4-bit motor output PIO.
- Avalon-MM slave on the Nios II data bus that sequences a unipolar stepper's coils in hardware, instead of software writing the raw coil pattern.
- Provides selectable full-step and half-step tables, a programmable step rate, a direction bit, a finite or continuous step count, and a completion interrupt.

Parameters:
- COILS, 4, coil output width; the tables are defined for 4 and elaboration errors out on any other value.
- DIV_WIDTH, 24, width of the step-period divider register.
- CNT_WIDTH, 16, width of the remaining-steps counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states, zero-extended.
- out_port  out  COILS  coil drive pattern.
- irq  out  1  level interrupt, equal to DONE & IRQ_EN.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All registers clear to 0 except idx, which resets to 1. out_port = 0, irq = 0.
- Register map. A write occurs when chipselect & ~write_n.
  - 0 CTRL (RW): bit0 EN, bit1 DIR (1 = idx increments), bit2 HALF, bit3 CONT, bit4 IRQ_EN.
  - 1 DIV (RW): step period minus 1, DIV_WIDTH bits.
  - 2 STEPS (RW): a write loads rem; a read returns rem.
  - 3 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; writing 1 clears it), bits[6:4] idx (RO).
- Half table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- out_port = EN ? table[idx] : 0. Coils are de-energised whenever EN = 0.
- run = EN & (CONT | rem != 0). BUSY = run.
- div_cnt:
  - Holds at 0 while run = 0.
  - Otherwise increments; at div_cnt == DIV it produces a one-cycle step pulse and wraps to 0.
  - DIV = 0 gives a step every cycle. Step period is DIV+1 clocks.
- On a step pulse:
  - Half mode: idx ± 1, mod 8.
  - Full mode: idx ± 2, mod 8, then idx[0] forced to 1. Full mode therefore walks only 1100, 0110, 0011, 1001.
  - If CONT = 0: rem decrements. If rem goes 1 -> 0, DONE is set in the same cycle.
- The new out_port pattern is visible the cycle after the step pulse (registered idx).
- Writing STEPS or DIV clears div_cnt, so the first step after the write occurs DIV+1 cycles later.
- A STEPS write coincident with a step pulse: the write wins. rem = writedata, with no decrement and no DONE set. idx still advances.
- Writing STEPS = 0 with CONT = 0: run stops immediately; DONE is not set.
- Clearing EN mid-move: run stops, rem and idx are held, and out_port goes to 0. Re-setting EN resumes from the same idx and rem.
- CONT = 1: rem is ignored and neither decremented nor altered; DONE is never set by stepping.
- A DONE set and a W1C clear in the same cycle: set wins.
- Unused readdata bits read as 0. Writes to STATUS bits other than bit1 are ignored.
- Reset asserted mid-move aborts immediately: out_port = 0, all state returns to its reset values.

Decomposition:
- Shared package stepper_pkg holds:
  - register address constants (CTRL, DIV, STEPS, STATUS);
  - CTRL bit indices;
  - the 8-entry half-step table constant.
- One sub-module, stepper_rate_div: a DIV_WIDTH counter with a clear input, producing a step pulse.
- Register file, sequencer and read mux stay in the top.

Test Plan:
- Reset, then read all four addresses -> every readdata = 0 except STATUS = 0x10 (idx = 1); out_port = 0; irq = 0.
- DIV = 3, STEPS = 4, CTRL = 0x13 (EN, DIR, IRQ_EN), full mode.
  - out_port sequence 1100 -> 0110 -> 0011 -> 1001 -> 1100, with steps 4 clocks apart.
  - Then rem = 0, BUSY = 0, DONE = 1, irq = 1.
  - Writing STATUS = 0x2 drops irq.
- CTRL = 0x05 (EN, HALF, DIR = 0), DIV = 0, STEPS = 3, starting from idx = 1 -> out_port 1100 -> 1000 -> 1001 -> 0001 on consecutive steps, every cycle; final idx = 6.
- CONT = 1, EN = 1, DIV = 1 -> steps every 2 clocks indefinitely; rem unchanged; DONE stays 0 after 20 steps.
- Mid-move, write CTRL with EN = 0 -> out_port = 0 next cycle; rem and idx frozen. Re-enable -> the first step comes DIV+1 clocks later from the same idx.
- Write STEPS = 5 in the cycle a step pulse fires with rem = 1 -> rem reads 5, DONE stays 0. Separately, assert reset_n low mid-move -> out_port = 0 asynchronously.
